// File: rtl/ula_control_unit.sv
// ula_control_unit: multicycle control FSM upstream of the ULA.
// Latches an instruction into IR, then sequences the bus drivers, the register
// loads and the ULA op code, one step per cycle, ending with a Done pulse.
// Optional build macro ULA_CU_ILLEGAL_TRAP_EN: when defined, an illegal opcode
// sets a sticky Illegal flag and locks the FSM in TRAP until Reset.
module ula_control_unit #(
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] IR,
  output logic              IRin,
  output logic [7:0]        Rout,
  output logic [7:0]        Rin,
  output logic              DINout,
  output logic              Gout,
  output logic              Ain,
  output logic              Gin,
  output logic [2:0]        Ulaop,
  output logic              Done,
  output logic              Illegal
);

  typedef enum logic [2:0] {
    T0,
    T1,
    T2,
    T3,
    TRAP
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;
  logic [2:0] alu_code;

  assign opcode = IR[15:12];
  assign rx     = IR[11:9];
  assign ry     = IR[8:6];

  // ADD..DEC4 occupy opcodes 2..7, which map onto ULA codes 0..5
  assign alu_code = 3'(opcode - 4'd2);

  function automatic logic [7:0] sel(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

  // State register and instruction register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= T0;
      IR    <= '0;
    end else begin
      state <= state_next;
      if (IRin) IR <= DIN;
    end
  end

  // Next-state and strobe decode from the current state and IR
  always_comb begin
    state_next = state;
    IRin       = 1'b0;
    Rout       = '0;
    Rin        = '0;
    DINout     = 1'b0;
    Gout       = 1'b0;
    Ain        = 1'b0;
    Gin        = 1'b0;
    Ulaop      = '0;
    Done       = 1'b0;
    case (state)
      T0: begin
        IRin = Run;
        if (Run) state_next = T1;
      end
      T1: begin
        case (opcode)
          4'h0: begin
            Rout       = sel(ry);
            Rin        = sel(rx);
            Done       = 1'b1;
            state_next = T0;
          end
          4'h1: begin
            DINout     = 1'b1;
            Rin        = sel(rx);
            Done       = 1'b1;
            state_next = T0;
          end
          4'h2, 4'h3, 4'h4, 4'h5: begin
            Rout       = sel(rx);
            Ain        = 1'b1;
            state_next = T2;
          end
          4'h6, 4'h7: begin
            // unary ops use only the bus operand, so the A-load step is skipped
            Rout       = sel(ry);
            Gin        = 1'b1;
            Ulaop      = alu_code;
            state_next = T3;
          end
          default: begin
`ifdef ULA_CU_ILLEGAL_TRAP_EN
            state_next = TRAP;
`else
            Done       = 1'b1;
            state_next = T0;
`endif
          end
        endcase
      end
      T2: begin
        Rout       = sel(ry);
        Gin        = 1'b1;
        Ulaop      = alu_code;
        state_next = T3;
      end
      T3: begin
        Gout       = 1'b1;
        Rin        = sel(rx);
        Done       = 1'b1;
        state_next = T0;
      end
      TRAP: state_next = TRAP;
      default: state_next = T0;
    endcase
  end

`ifdef ULA_CU_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky illegal-opcode flag, cleared only by Reset
  always_ff @(posedge Clock) begin
    if (Reset) illegal_q <= 1'b0;
    else if (state == T1 && opcode[3]) illegal_q <= 1'b1;
  end

  assign Illegal = illegal_q;
`else
  assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_ula_control_unit.sv
// Testbench for ula_control_unit: per-cycle expected outputs are queued as
// stimulus is applied and popped for comparison once the outputs settle.
module tb_ula_control_unit;

  logic        Clock;
  logic        Reset;
  logic        Run;
  logic [15:0] DIN;
  logic [15:0] IR;
  logic        IRin;
  logic [7:0]  Rout;
  logic [7:0]  Rin;
  logic        DINout;
  logic        Gout;
  logic        Ain;
  logic        Gin;
  logic [2:0]  Ulaop;
  logic        Done;
  logic        Illegal;

  typedef struct packed {
    logic [15:0] ir;
    logic        irin;
    logic [7:0]  rout;
    logic [7:0]  rin;
    logic        dinout;
    logic        gout;
    logic        ain;
    logic        gin;
    logic [2:0]  ulaop;
    logic        done;
    logic        ill;
  } outs_t;

  typedef struct packed {
    logic        rst;
    logic        run;
    logic [15:0] din;
    outs_t       exp;
  } stim_t;

  stim_t plan[$];
  outs_t sb[$];
  outs_t got;
  outs_t expv;
  int    compared   = 0;
  int    mismatched = 0;

  ula_control_unit #(.DATA_W(16)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Run    (Run),
    .DIN    (DIN),
    .IR     (IR),
    .IRin   (IRin),
    .Rout   (Rout),
    .Rin    (Rin),
    .DINout (DINout),
    .Gout   (Gout),
    .Ain    (Ain),
    .Gin    (Gin),
    .Ulaop  (Ulaop),
    .Done   (Done),
    .Illegal(Illegal)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic outs_t mk(input logic [15:0] ir, input logic irin,
                               input logic [7:0] rout, input logic [7:0] rin,
                               input logic dinout, input logic gout,
                               input logic ain, input logic gin,
                               input logic [2:0] ulaop, input logic done,
                               input logic ill);
    outs_t o;
    o.ir = ir; o.irin = irin; o.rout = rout; o.rin = rin;
    o.dinout = dinout; o.gout = gout; o.ain = ain; o.gin = gin;
    o.ulaop = ulaop; o.done = done; o.ill = ill;
    return o;
  endfunction

  function automatic outs_t idle(input logic [15:0] ir, input logic ill);
    return mk(ir, 0, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0, ill);
  endfunction

  task automatic add(input logic rst, input logic run, input logic [15:0] din, input outs_t e);
    stim_t s;
    s.rst = rst; s.run = run; s.din = din; s.exp = e;
    plan.push_back(s);
  endtask

  task automatic test_reset;
    add(1, 0, 16'h0000, idle(16'h0000, 0));
    add(0, 1, 16'h2440, mk(16'h0000, 1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0, 0));
    add(0, 0, 16'h0000, mk(16'h2440, 0, 8'h04, 8'h00, 0, 0, 1, 0, 3'b000, 0, 0));
    add(1, 0, 16'h0000, mk(16'h2440, 0, 8'h02, 8'h00, 0, 0, 0, 1, 3'b000, 0, 0));
    add(1, 0, 16'h0000, idle(16'h0000, 0));
    add(0, 0, 16'h0000, idle(16'h0000, 0));
    add(0, 0, 16'h0000, idle(16'h0000, 0));
    foreach (plan[i]) begin
      Reset = plan[i].rst; Run = plan[i].run; DIN = plan[i].din;
      sb.push_back(plan[i].exp);
      #1;
      got  = {IR, IRin, Rout, Rin, DINout, Gout, Ain, Gin, Ulaop, Done, Illegal};
      expv = sb.pop_front();
      compared++;
      if (got !== expv) begin
        mismatched++;
        $display("FAIL reset[%0d] got=%h expected=%h", i, got, expv);
      end
      @(posedge Clock); @(negedge Clock);
    end
    plan.delete();
  endtask

  task automatic test_mvi;
    add(0, 1, 16'h1200, mk(16'h0000, 1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0, 0));
    add(0, 0, 16'h00A5, mk(16'h1200, 0, 8'h00, 8'h02, 1, 0, 0, 0, 3'b000, 1, 0));
    add(0, 0, 16'h0000, idle(16'h1200, 0));
    foreach (plan[i]) begin
      Reset = plan[i].rst; Run = plan[i].run; DIN = plan[i].din;
      sb.push_back(plan[i].exp);
      #1;
      got  = {IR, IRin, Rout, Rin, DINout, Gout, Ain, Gin, Ulaop, Done, Illegal};
      expv = sb.pop_front();
      compared++;
      if (got !== expv) begin
        mismatched++;
        $display("FAIL mvi[%0d] got=%h expected=%h", i, got, expv);
      end
      @(posedge Clock); @(negedge Clock);
    end
    plan.delete();
  endtask

  task automatic test_binary;
    add(0, 1, 16'h2440, mk(16'h1200, 1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0, 0));
    add(0, 0, 16'h0000, mk(16'h2440, 0, 8'h04, 8'h00, 0, 0, 1, 0, 3'b000, 0, 0));
    add(0, 0, 16'h0000, mk(16'h2440, 0, 8'h02, 8'h00, 0, 0, 0, 1, 3'b000, 0, 0));
    add(0, 0, 16'h0000, mk(16'h2440, 0, 8'h00, 8'h04, 0, 1, 0, 0, 3'b000, 1, 0));
    add(0, 0, 16'h0000, idle(16'h2440, 0));
    foreach (plan[i]) begin
      Reset = plan[i].rst; Run = plan[i].run; DIN = plan[i].din;
      sb.push_back(plan[i].exp);
      #1;
      got  = {IR, IRin, Rout, Rin, DINout, Gout, Ain, Gin, Ulaop, Done, Illegal};
      expv = sb.pop_front();
      compared++;
      if (got !== expv) begin
        mismatched++;
        $display("FAIL binary[%0d] got=%h expected=%h", i, got, expv);
      end
      @(posedge Clock); @(negedge Clock);
    end
    plan.delete();
  endtask

  task automatic test_inc_dec;
    add(0, 1, 16'h6680, mk(16'h2440, 1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0, 0));
    add(0, 0, 16'h0000, mk(16'h6680, 0, 8'h04, 8'h00, 0, 0, 0, 1, 3'b100, 0, 0));
    add(0, 0, 16'h0000, mk(16'h6680, 0, 8'h00, 8'h08, 0, 1, 0, 0, 3'b000, 1, 0));
    add(0, 1, 16'h7680, mk(16'h6680, 1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0, 0));
    add(0, 0, 16'h0000, mk(16'h7680, 0, 8'h04, 8'h00, 0, 0, 0, 1, 3'b101, 0, 0));
    add(0, 0, 16'h0000, mk(16'h7680, 0, 8'h00, 8'h08, 0, 1, 0, 0, 3'b000, 1, 0));
    add(0, 0, 16'h0000, idle(16'h7680, 0));
    foreach (plan[i]) begin
      Reset = plan[i].rst; Run = plan[i].run; DIN = plan[i].din;
      sb.push_back(plan[i].exp);
      #1;
      got  = {IR, IRin, Rout, Rin, DINout, Gout, Ain, Gin, Ulaop, Done, Illegal};
      expv = sb.pop_front();
      compared++;
      if (got !== expv) begin
        mismatched++;
        $display("FAIL inc_dec[%0d] got=%h expected=%h", i, got, expv);
      end
      @(posedge Clock); @(negedge Clock);
    end
    plan.delete();
  endtask

  task automatic test_mv;
    add(0, 1, 16'h06C0, mk(16'h7680, 1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0, 0));
    add(0, 1, 16'h0340, mk(16'h06C0, 0, 8'h08, 8'h08, 0, 0, 0, 0, 3'b000, 1, 0));
    add(0, 1, 16'h0340, mk(16'h06C0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0, 0));
    add(0, 0, 16'h0000, mk(16'h0340, 0, 8'h20, 8'h02, 0, 0, 0, 0, 3'b000, 1, 0));
    add(0, 0, 16'h0000, idle(16'h0340, 0));
    foreach (plan[i]) begin
      Reset = plan[i].rst; Run = plan[i].run; DIN = plan[i].din;
      sb.push_back(plan[i].exp);
      #1;
      got  = {IR, IRin, Rout, Rin, DINout, Gout, Ain, Gin, Ulaop, Done, Illegal};
      expv = sb.pop_front();
      compared++;
      if (got !== expv) begin
        mismatched++;
        $display("FAIL mv[%0d] got=%h expected=%h", i, got, expv);
      end
      @(posedge Clock); @(negedge Clock);
    end
    plan.delete();
  endtask

  task automatic test_back_to_back;
    add(0, 1, 16'h3240, mk(16'h0340, 1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0, 0));
    add(0, 1, 16'h4240, mk(16'h3240, 0, 8'h02, 8'h00, 0, 0, 1, 0, 3'b000, 0, 0));
    add(0, 1, 16'h4240, mk(16'h3240, 0, 8'h02, 8'h00, 0, 0, 0, 1, 3'b001, 0, 0));
    add(0, 1, 16'h4240, mk(16'h3240, 0, 8'h00, 8'h02, 0, 1, 0, 0, 3'b000, 1, 0));
    add(0, 1, 16'h4240, mk(16'h3240, 1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0, 0));
    add(0, 1, 16'h5240, mk(16'h4240, 0, 8'h02, 8'h00, 0, 0, 1, 0, 3'b000, 0, 0));
    add(0, 1, 16'h5240, mk(16'h4240, 0, 8'h02, 8'h00, 0, 0, 0, 1, 3'b010, 0, 0));
    add(0, 0, 16'h5240, mk(16'h4240, 0, 8'h00, 8'h02, 0, 1, 0, 0, 3'b000, 1, 0));
    add(0, 0, 16'h0000, idle(16'h4240, 0));
    foreach (plan[i]) begin
      Reset = plan[i].rst; Run = plan[i].run; DIN = plan[i].din;
      sb.push_back(plan[i].exp);
      #1;
      got  = {IR, IRin, Rout, Rin, DINout, Gout, Ain, Gin, Ulaop, Done, Illegal};
      expv = sb.pop_front();
      compared++;
      if (got !== expv) begin
        mismatched++;
        $display("FAIL back_to_back[%0d] got=%h expected=%h", i, got, expv);
      end
      @(posedge Clock); @(negedge Clock);
    end
    plan.delete();
  endtask

  task automatic test_illegal;
    add(0, 1, 16'hF000, mk(16'h4240, 1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0, 0));
`ifdef ULA_CU_ILLEGAL_TRAP_EN
    add(0, 0, 16'h0000, idle(16'hF000, 0));
    for (int k = 0; k < 10; k++) add(0, 1, 16'h1200, idle(16'hF000, 1));
    add(1, 0, 16'h0000, idle(16'hF000, 1));
    add(0, 0, 16'h0000, idle(16'h0000, 0));
`else
    add(0, 0, 16'h0000, mk(16'hF000, 0, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 1, 0));
    add(0, 1, 16'h0340, mk(16'hF000, 1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0, 0));
    add(0, 0, 16'h0000, mk(16'h0340, 0, 8'h20, 8'h02, 0, 0, 0, 0, 3'b000, 1, 0));
    add(0, 0, 16'h0000, idle(16'h0340, 0));
`endif
    foreach (plan[i]) begin
      Reset = plan[i].rst; Run = plan[i].run; DIN = plan[i].din;
      sb.push_back(plan[i].exp);
      #1;
      got  = {IR, IRin, Rout, Rin, DINout, Gout, Ain, Gin, Ulaop, Done, Illegal};
      expv = sb.pop_front();
      compared++;
      if (got !== expv) begin
        mismatched++;
        $display("FAIL illegal[%0d] got=%h expected=%h", i, got, expv);
      end
      @(posedge Clock); @(negedge Clock);
    end
    plan.delete();
  endtask

  initial begin
    Reset = 1'b1;
    Run   = 1'b0;
    DIN   = 16'h0000;
    @(negedge Clock);
    @(negedge Clock);
    test_reset;
    test_mvi;
    test_binary;
    test_inc_dec;
    test_mv;
    test_back_to_back;
    test_illegal;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
